gf180mcu_clkdiv_prog: RTL and testbench

- Programmable, glitch-free clock divider. Registered output Z drives the I pin of the clkinv cells in the divided-clock tree.
- Divide ratio and run/stop change only at period boundaries, so the downstream inverters never see a runt pulse.
- Used for low-frequency peripheral clock domains in the 7-track 5V0 library flow.

---
 rtl/gf180mcu_clkdiv_prog.sv | 131 +++++++++++++
 tb/tb_gf180mcu_clkdiv_prog.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_clkdiv_prog.sv
// rtl/gf180mcu_clkdiv_prog.sv - programmable glitch-free clock divider, ratio/run changes at period boundaries.
// Optional 50% duty for odd ratios via macro GF180MCU_CLKDIV_DUTY50_EN (adds a negedge flop).
module gf180mcu_clkdiv_prog #(
    parameter int WIDTH   = 4,
    parameter int DIV_RST = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LD,
    output logic             ACK,
    output logic             Z,
    output logic             RUNNING
);

    localparam int DIV_RST_CLAMPED = (DIV_RST < 2) ? 2 : DIV_RST;
    localparam logic [WIDTH-1:0] NACT_RST = DIV_RST_CLAMPED[WIDTH-1:0];

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] nact, nact_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic             pend_vld, pend_vld_n;
    logic             zr, zr_n;
    logic             ack_n;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] div_clamped;
    logic             boundary;

    assign half        = nact >> 1;
    assign div_clamped = (DIV < WIDTH'(2)) ? WIDTH'(2) : DIV;
    assign boundary    = (cnt == nact - WIDTH'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            nact     <= NACT_RST;
            pend     <= '0;
            pend_vld <= 1'b0;
            zr       <= 1'b0;
            ACK      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            nact     <= nact_n;
            pend     <= pend_n;
            pend_vld <= pend_vld_n;
            zr       <= zr_n;
            ACK      <= ack_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        nact_n     = nact;
        pend_n     = pend;
        pend_vld_n = pend_vld;
        zr_n       = zr;
        ack_n      = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                zr_n  = 1'b0;
                // No period is running, so a load (or a leftover pending ratio) takes effect at once.
                if (LD) begin
                    nact_n     = div_clamped;
                    ack_n      = 1'b1;
                    pend_vld_n = 1'b0;
                end else if (pend_vld) begin
                    nact_n     = pend;
                    ack_n      = 1'b1;
                    pend_vld_n = 1'b0;
                end
                if (EN) begin
                    state_n = RUN;
                    zr_n    = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_n = '0;
                    if (pend_vld) begin
                        nact_n     = pend;
                        ack_n      = 1'b1;
                        pend_vld_n = 1'b0;
                    end
                    if (EN) begin
                        zr_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        zr_n    = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + WIDTH'(1);
                    zr_n  = ((cnt + WIDTH'(1)) < half);
                end
                // A load on the boundary edge queues behind the ratio being applied there.
                if (LD) begin
                    pend_n     = div_clamped;
                    pend_vld_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign RUNNING = (state == RUN);

`ifdef GF180MCU_CLKDIV_DUTY50_EN
    logic zf;

    // Holds the high phase half a cycle longer for odd ratios.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            zf <= 1'b0;
        end else begin
            zf <= zr & nact[0];
        end
    end

    assign Z = zr | zf;
`else
    assign Z = zr;
`endif

endmodule

// File: tb/tb_gf180mcu_clkdiv_prog.sv
// tb/tb_gf180mcu_clkdiv_prog.sv - directed self-checking bench for gf180mcu_clkdiv_prog.
module tb_gf180mcu_clkdiv_prog;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] DIV;
    logic       LD;
    logic       ACK;
    logic       Z;
    logic       RUNNING;

    int n_cmp = 0;
    int n_err = 0;

    gf180mcu_clkdiv_prog #(.WIDTH(4), .DIV_RST(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV), .LD(LD),
        .ACK(ACK), .Z(Z), .RUNNING(RUNNING)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starting from CNT=0 of a running period of ratio n, walk one full period and back to CNT=0.
    task automatic run_period(input string tag, input int n);
        for (int c = 1; c < n; c++) begin
            step();
            chk(tag, {31'd0, Z}, (c < n / 2) ? 32'd1 : 32'd0);
            chk({tag, "_ack"}, {31'd0, ACK}, 32'd0);
        end
        step();
        chk({tag, "_wrap"}, {31'd0, Z}, 32'd1);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; DIV = 4'd0; LD = 1'b0;
        step();
        chk("rst_z", {31'd0, Z}, 32'd0);
        chk("rst_ack", {31'd0, ACK}, 32'd0);
        chk("rst_running", {31'd0, RUNNING}, 32'd0);

        // Reset ratio 2: Z toggles 1,0,1,0 from the first edge.
        RST = 1'b0; EN = 1'b1;
        step();
        chk("n2_start_z", {31'd0, Z}, 32'd1);
        chk("n2_running", {31'd0, RUNNING}, 32'd1);
        chk("n2_ack", {31'd0, ACK}, 32'd0);
        step(); chk("n2_z1", {31'd0, Z}, 32'd0);
        step(); chk("n2_z2", {31'd0, Z}, 32'd1);
        step(); chk("n2_z3", {31'd0, Z}, 32'd0);
        chk("n2_ack_end", {31'd0, ACK}, 32'd0);

        // Stop at the boundary, then load 4 in IDLE.
        EN = 1'b0;
        step();
        chk("stop_z", {31'd0, Z}, 32'd0);
        chk("stop_running", {31'd0, RUNNING}, 32'd0);
        LD = 1'b1; DIV = 4'd4;
        step();
        chk("idle_ld_ack", {31'd0, ACK}, 32'd1);
        chk("idle_ld_z", {31'd0, Z}, 32'd0);
        LD = 1'b0; EN = 1'b1;
        step();
        chk("idle_ld_ack_low", {31'd0, ACK}, 32'd0);
        chk("n4_start_z", {31'd0, Z}, 32'd1);
        run_period("n4_p1", 4);
        run_period("n4_p2", 4);

        // Running N=4, load 6 at CNT=1: current period completes, ACK on boundary.
        step(); chk("ld6_cnt1_z", {31'd0, Z}, 32'd1);
        LD = 1'b1; DIV = 4'd6;
        step(); chk("ld6_cnt2_z", {31'd0, Z}, 32'd0);
        chk("ld6_cnt2_ack", {31'd0, ACK}, 32'd0);
        LD = 1'b0;
        step(); chk("ld6_cnt3_z", {31'd0, Z}, 32'd0);
        step();
        chk("ld6_bnd_z", {31'd0, Z}, 32'd1);
        chk("ld6_bnd_ack", {31'd0, ACK}, 32'd1);
        run_period("n6", 6);

        // DIV=0 then DIV=3 before the boundary: one ACK, N=3 applies.
        step();
        LD = 1'b1; DIV = 4'd0;
        step();
        DIV = 4'd3;
        step();
        LD = 1'b0;
        step(); chk("ovr_cnt4_ack", {31'd0, ACK}, 32'd0);
        step(); chk("ovr_cnt5_ack", {31'd0, ACK}, 32'd0);
        step();
        chk("ovr_bnd_ack", {31'd0, ACK}, 32'd1);
        chk("ovr_bnd_z", {31'd0, Z}, 32'd1);
        run_period("n3", 3);

        // Back to N=6, then drop EN at CNT=2.
        LD = 1'b1; DIV = 4'd6;
        step();
        LD = 1'b0;
        step();
        step(); chk("n6b_bnd_ack", {31'd0, ACK}, 32'd1);
        step();
        step();
        chk("en0_cnt2_z", {31'd0, Z}, 32'd1);
        EN = 1'b0;
        step(); chk("en0_cnt3_z", {31'd0, Z}, 32'd0);
        step();
        step();
        chk("en0_cnt5_running", {31'd0, RUNNING}, 32'd1);
        step();
        chk("en0_idle_running", {31'd0, RUNNING}, 32'd0);
        chk("en0_idle_z", {31'd0, Z}, 32'd0);
        step();
        chk("en0_idle2_z", {31'd0, Z}, 32'd0);
        EN = 1'b1;
        step();
        chk("restart_z", {31'd0, Z}, 32'd1);
        chk("restart_running", {31'd0, RUNNING}, 32'd1);

        // Pending 9 at CNT=1, then async reset mid-cycle discards it.
        LD = 1'b1; DIV = 4'd9;
        step();
        LD = 1'b0;
        chk("prerst_z", {31'd0, Z}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_z", {31'd0, Z}, 32'd0);
        chk("async_rst_running", {31'd0, RUNNING}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        step();
        chk("postrst_z0", {31'd0, Z}, 32'd1);
        chk("postrst_ack", {31'd0, ACK}, 32'd0);
        step(); chk("postrst_z1", {31'd0, Z}, 32'd0);
        chk("postrst_ack1", {31'd0, ACK}, 32'd0);
        step(); chk("postrst_z2", {31'd0, Z}, 32'd1);
        step(); chk("postrst_z3", {31'd0, Z}, 32'd0);

        // Odd ratio 5 (high 2, low 3), then the maximum ratio 15.
        EN = 1'b0;
        step();
        LD = 1'b1; DIV = 4'd5;
        step();
        chk("n5_ld_ack", {31'd0, ACK}, 32'd1);
        LD = 1'b0; EN = 1'b1;
        step();
        chk("n5_start_z", {31'd0, Z}, 32'd1);
        run_period("n5", 5);
        EN = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("n5_stop_running", {31'd0, RUNNING}, 32'd0);
        LD = 1'b1; DIV = 4'd15;
        step();
        LD = 1'b0; EN = 1'b1;
        step();
        chk("n15_start_z", {31'd0, Z}, 32'd1);
        run_period("n15", 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
